// File: rtl/sram_ctrl_bridge_if.sv
// sram_ctrl_bridge_if: memory-stage request bus between the pipeline and the SRAM bridge.
// The pipeline drives the request side (master); the bridge returns data and ready (slave).
interface sram_ctrl_bridge_if;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output rd_en,
        output wr_en,
        output address,
        output write_data,
        input  read_data,
        input  ready
    );

    modport slave (
        input  rd_en,
        input  wr_en,
        input  address,
        input  write_data,
        output read_data,
        output ready
    );
endinterface

// File: rtl/sram_ctrl_bridge.sv
// sram_ctrl_bridge: turns one 32-bit load/store into two 16-bit SRAM half-word accesses
// (low half first), each held WAIT_CYCLES cycles, and stalls the pipeline via ready.
// Optional feature: define SRAM_CTRL_RDBUF_EN for a one-entry read buffer that lets a
// repeated load of the last-read word finish without touching the SRAM.
module sram_ctrl_bridge #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    sram_ctrl_bridge_if.slave bus,
    inout  wire  [15:0]       SRAM_DQ,
    output logic [17:0]       SRAM_ADDR,
    output logic              SRAM_WE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N
);

    typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

    localparam logic [3:0] LastCnt = 4'(WAIT_CYCLES - 1);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        op_wr_q;
    logic [16:0] word_q;
    logic [31:0] wdata_q;
    logic [31:0] read_data_q;
    logic        dq_oe_q;
    logic [15:0] dq_out_q;

    logic        req;
    logic        skip;
    logic [31:0] off;
    logic [16:0] req_word;
    logic        unused_off;

    // Offset wraps by truncation; byte-lane bits and bits above the SRAM range are dropped.
    assign off        = bus.address - BASE_ADDR;
    assign req_word   = off[18:2];
    assign unused_off = ^{off[31:19], off[1:0]};

    assign req           = bus.rd_en | bus.wr_en;
    assign bus.ready     = ~req | (state_q == StDone);
    assign bus.read_data = read_data_q;
    assign SRAM_DQ       = dq_oe_q ? dq_out_q : 16'bz;

`ifdef SRAM_CTRL_RDBUF_EN
    logic        buf_valid_q;
    logic [16:0] buf_tag_q;

    assign skip = ~bus.wr_en & buf_valid_q & (buf_tag_q == req_word);

    // Read buffer: filled when a read completes its HIGH phase, dropped when a write starts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
        end else if (state_q == StIdle && bus.wr_en) begin
            buf_valid_q <= 1'b0;
        end else if (state_q == StHigh && cnt_q == LastCnt && !op_wr_q) begin
            buf_valid_q <= 1'b1;
            buf_tag_q   <= word_q;
        end
    end
`else
    assign skip = 1'b0;
`endif

    // Transfer FSM; all SRAM pins are registered so they change only with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            op_wr_q     <= 1'b0;
            word_q      <= '0;
            wdata_q     <= '0;
            read_data_q <= '0;
            SRAM_ADDR   <= '0;
            SRAM_WE_N   <= 1'b1;
            SRAM_UB_N   <= 1'b1;
            SRAM_LB_N   <= 1'b1;
            SRAM_CE_N   <= 1'b1;
            SRAM_OE_N   <= 1'b1;
            dq_oe_q     <= 1'b0;
            dq_out_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        op_wr_q <= bus.wr_en;
                        word_q  <= req_word;
                        wdata_q <= bus.write_data;
                        cnt_q   <= '0;
                        if (skip) begin
                            state_q <= StDone;
                        end else begin
                            state_q   <= StLow;
                            SRAM_ADDR <= {req_word, 1'b0};
                            SRAM_CE_N <= 1'b0;
                            SRAM_UB_N <= 1'b0;
                            SRAM_LB_N <= 1'b0;
                            SRAM_OE_N <= bus.wr_en;
                            SRAM_WE_N <= ~bus.wr_en;
                            dq_oe_q   <= bus.wr_en;
                            dq_out_q  <= bus.write_data[15:0];
                        end
                    end
                end
                StLow: begin
                    if (cnt_q == LastCnt) begin
                        cnt_q     <= '0;
                        state_q   <= StHigh;
                        SRAM_ADDR <= {word_q, 1'b1};
                        dq_out_q  <= wdata_q[31:16];
                        if (!op_wr_q) read_data_q[15:0] <= SRAM_DQ;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                StHigh: begin
                    if (cnt_q == LastCnt) begin
                        cnt_q     <= '0;
                        state_q   <= StDone;
                        SRAM_ADDR <= '0;
                        SRAM_WE_N <= 1'b1;
                        SRAM_UB_N <= 1'b1;
                        SRAM_LB_N <= 1'b1;
                        SRAM_CE_N <= 1'b1;
                        SRAM_OE_N <= 1'b1;
                        dq_oe_q   <= 1'b0;
                        if (!op_wr_q) read_data_q[31:16] <= SRAM_DQ;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl_bridge.sv
// tb_sram_ctrl_bridge: directed vector table of load/store transfers against a behavioural
// 16-bit SRAM, plus hand sequences for reset-during-write and the optional read buffer.
module tb_sram_ctrl_bridge;

    localparam int W        = 2;
    localparam int FULL_LAT = 5;
`ifdef SRAM_CTRL_RDBUF_EN
    localparam int HIT_LAT = 1;
`else
    localparam int HIT_LAT = 5;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        we_n, ub_n, lb_n, ce_n, oe_n;

    int n_vec = 0;
    int n_bad = 0;

    sram_ctrl_bridge_if bus ();

    sram_ctrl_bridge #(
        .BASE_ADDR  (32'd1024),
        .WAIT_CYCLES(W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .SRAM_DQ  (sram_dq),
        .SRAM_ADDR(sram_addr),
        .SRAM_WE_N(we_n),
        .SRAM_UB_N(ub_n),
        .SRAM_LB_N(lb_n),
        .SRAM_CE_N(ce_n),
        .SRAM_OE_N(oe_n)
    );

    always #5 clk = ~clk;

    // Undriven bus reads as all ones, so a released DQ is observable.
    pullup (sram_dq);

    // Behavioural SRAM: 1024 half-words, preset to 16'h7000 | index.
    logic [15:0] mem [0:1023];
    logic        init_done = 1'b0;
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 16'h7000 | 16'(i);
            init_done <= 1'b1;
        end else if (!ce_n && !we_n) begin
            mem[sram_addr[9:0]] <= sram_dq;
        end
    end
    assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr[9:0]] : 16'bz;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // One transfer: drive at cycle 0, check pins per phase cycle, latency, and DONE state.
    task automatic xfer(input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [17:0] base, input int exp_lat,
                        input logic [31:0] exp_rd, input logic hold);
        int   lat;
        logic hi;
        @(negedge clk);
        bus.wr_en      = wr;
        bus.rd_en      = rd;
        bus.address    = addr;
        bus.write_data = wd;
        #1;
        chk("ready_cycle0", 32'(bus.ready), 0);
        chk("ctl_cycle0", 32'({ce_n, ub_n, lb_n, oe_n, we_n}), 32'h1f);
        lat = 0;
        while (!bus.ready && lat < 20) begin
            @(negedge clk);
            #1;
            lat++;
            if (exp_lat == 1) begin
                chk("hit_ctl_idle", 32'({ce_n, ub_n, lb_n, oe_n, we_n}), 32'h1f);
            end else if (lat <= 2 * W) begin
                hi = (lat > W);
                chk("phase_addr", 32'(sram_addr), 32'(base) + 32'(hi));
                chk("phase_ctl", 32'({ce_n, ub_n, lb_n, oe_n, we_n}),
                    wr ? 32'b00010 : 32'b00001);
                if (wr) chk("phase_dq", 32'(sram_dq), hi ? 32'(wd[31:16]) : 32'(wd[15:0]));
            end
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("done_ctl", 32'({ce_n, ub_n, lb_n, oe_n, we_n}), 32'h1f);
        chk("done_addr", 32'(sram_addr), 0);
        chk("done_dq_z", 32'(sram_dq), 32'hffff);
        chk("read_data", bus.read_data, exp_rd);
        if (wr) begin
            chk("mem_lo", 32'(mem[base[9:0]]), 32'(wd[15:0]));
            chk("mem_hi", 32'(mem[base[9:0] + 10'd1]), 32'(wd[31:16]));
        end
        if (!hold) begin
            bus.wr_en = 1'b0;
            bus.rd_en = 1'b0;
        end
    endtask

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [17:0] base;
        logic [31:0] exp_rd;
        logic        hold;
    } vec_t;

    vec_t vt [9];

    initial begin
        // Hand-computed: word = (addr-1024)[18:2]; base = {word,0}. Address 0 underflows to 0x3FE00.
        vt[0] = '{1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 18'd2,       32'h0,        1'b0};
        vt[1] = '{1'b0, 1'b1, 32'd1028, 32'h0,        18'd2,       32'hDEADBEEF, 1'b0};
        vt[2] = '{1'b1, 1'b0, 32'd1032, 32'hCAFEF00D, 18'd4,       32'hDEADBEEF, 1'b1};
        vt[3] = '{1'b0, 1'b1, 32'd1032, 32'h0,        18'd4,       32'hCAFEF00D, 1'b0};
        vt[4] = '{1'b1, 1'b1, 32'd1036, 32'h12345678, 18'd6,       32'hCAFEF00D, 1'b0};
        vt[5] = '{1'b0, 1'b1, 32'd1039, 32'h0,        18'd6,       32'h12345678, 1'b0};
        vt[6] = '{1'b1, 1'b0, 32'd0,    32'hA5A55A5A, 18'h3FE00,   32'h12345678, 1'b0};
        vt[7] = '{1'b0, 1'b1, 32'd0,    32'h0,        18'h3FE00,   32'hA5A55A5A, 1'b0};
        vt[8] = '{1'b0, 1'b1, 32'd1028, 32'h0,        18'd2,       32'hDEADBEEF, 1'b0};

        bus.rd_en      = 1'b0;
        bus.wr_en      = 1'b0;
        bus.address    = '0;
        bus.write_data = '0;

        // Reset held with random requests: everything idle, ready follows the request.
        repeat (2) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.rd_en      = 1'($urandom_range(0, 1));
            bus.wr_en      = 1'($urandom_range(0, 1));
            bus.address    = $urandom;
            bus.write_data = $urandom;
            #1;
            chk("rst_read_data", bus.read_data, 0);
            chk("rst_ctl", 32'({ce_n, ub_n, lb_n, oe_n, we_n}), 32'h1f);
            chk("rst_addr", 32'(sram_addr), 0);
            chk("rst_dq_z", 32'(sram_dq), 32'hffff);
            chk("rst_ready", 32'(bus.ready), 32'(!(bus.rd_en || bus.wr_en)));
        end
        @(negedge clk);
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
        rst       = 1'b1;
        #1;
        chk("idle_ready", 32'(bus.ready), 1);

        for (int v = 0; v < 9; v++) begin
            xfer(vt[v].wr, vt[v].rd, vt[v].addr, vt[v].wd, vt[v].base, FULL_LAT,
                 vt[v].exp_rd, vt[v].hold);
        end

        // Repeat load of the last-read word, then store and reload it.
        xfer(1'b0, 1'b1, 32'd1028, 32'h0, 18'd2, HIT_LAT, 32'hDEADBEEF, 1'b0);
        xfer(1'b1, 1'b0, 32'd1028, 32'h0BADF00D, 18'd2, FULL_LAT, 32'hDEADBEEF, 1'b0);
        xfer(1'b0, 1'b1, 32'd1028, 32'h0, 18'd2, FULL_LAT, 32'h0BADF00D, 1'b0);

        // Reset in the first HIGH cycle of a store to 1044 (half-words 10/11).
        @(negedge clk);
        bus.wr_en      = 1'b1;
        bus.address    = 32'd1044;
        bus.write_data = 32'h11112222;
        repeat (W + 1) @(negedge clk);
        #1;
        chk("mid_high_addr", 32'(sram_addr), 11);
        chk("mid_high_dq", 32'(sram_dq), 32'h1111);
        rst = 1'b0;
        #1;
        chk("async_ctl", 32'({ce_n, ub_n, lb_n, oe_n, we_n}), 32'h1f);
        chk("async_addr", 32'(sram_addr), 0);
        chk("async_dq_z", 32'(sram_dq), 32'hffff);
        chk("async_read_data", bus.read_data, 0);
        repeat (2) @(negedge clk);
        chk("abort_mem_lo", 32'(mem[10]), 32'h2222);
        chk("abort_mem_hi", 32'(mem[11]), 32'h700B);
        bus.wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        xfer(1'b0, 1'b1, 32'd1044, 32'h0, 18'd10, FULL_LAT, 32'h700B2222, 1'b0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
